unified_mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port and data-memory (M-stage) port.
- Grants one access at a time and returns read data with a one-cycle valid pulse to the owner.
- Data side has priority; a streak counter bounds fetch starvation.
- Sits between the core pipeline and the unified memory, replacing the separate instruction and data memories.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_prio.sv | 52 +++++
 rtl/unified_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, port ownership
// and the latency counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Wide enough to hold MEM_LAT-1 for any MEM_LAT up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data ports: data wins by default, but a
// streak of data wins against a waiting fetch eventually forces a fetch grant.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_allowed,
  output logic if_gnt,
  output logic dm_gnt
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          force_if;

  assign force_if = (streak_q == STREAK_MAX);

  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    streak_d = streak_q;
    if (grant_allowed) begin
      if (dm_req && !(if_req && force_if)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
    // Only data wins taken while fetch was waiting count toward starvation.
    if (if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && if_req && !force_if) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// data ports; one access in flight, response returned as a one-cycle pulse.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  // Handshake: a requester holds req and its fields stable until gnt; gnt
  // qualifies mem_* in that same cycle; rvalid is a one-cycle completion pulse.
  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
  logic               grant_allowed;

  // No grant while reset is held so the memory side stays quiet.
  assign grant_allowed = reset && ((state_q == IDLE) || (state_q == RESP));

  mem_arb_prio #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_prio (
    .clk           (clk),
    .reset         (reset),
    .if_req        (if_req),
    .dm_req        (dm_req),
    .grant_allowed (grant_allowed),
    .if_gnt        (if_gnt),
    .dm_gnt        (dm_gnt)
  );

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (if_gnt || dm_gnt) begin
          state_d = WAIT;
          owner_d = dm_gnt ? OWN_DM : OWN_IF;
          we_d    = dm_gnt & dm_we;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // cnt_q reaches zero in the cycle mem_rdata is valid.
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = we_q ? '0 : mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_rvalid = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: MEM_LAT=2 instance for the main
// scenarios plus a MEM_LAT=1 instance, each backed by a small memory model.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk;
  logic        reset;

  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        if_req1, if_gnt1, if_rvalid1;
  logic [31:0] if_addr1, if_rdata1;
  logic        dm_req1, dm_we1, dm_gnt1, dm_rvalid1;
  logic [31:0] dm_addr1, dm_wdata1, dm_rdata1;
  logic [3:0]  dm_be1;
  logic        mem_en1, mem_we1, busy1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;

  int errors = 0;
  int checks = 0;

  logic [31:0] wmem [logic [31:0]];
  logic [31:0] p0, p1, q0;
  logic        exp_dm [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_DSTREAK(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DSTREAK(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1), .dm_be(dm_be1),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_be(mem_be1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory models: data appears MEM_LAT cycles after mem_en, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      logic [31:0] cur;
      cur = rd_model(mem_addr);
      for (int b = 0; b < 4; b++) if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
      wmem[mem_addr] = cur;
    end
    p0 <= (mem_en && !mem_we) ? rd_model(mem_addr) : BAD;
    p1 <= p0;
    q0 <= (mem_en1 && !mem_we1) ? rd_model(mem_addr1) : BAD;
  end
  assign mem_rdata  = p1;
  assign mem_rdata1 = q0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    if_req1 = 0; if_addr1 = 0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = 0; dm_wdata1 = 0; dm_be1 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_dm_rvalid", 32'(dm_rvalid), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    if_req = 1; if_addr = 32'h100;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    if_req = 0;
    @(negedge clk); reset = 1'b1;

    // Single fetch
    @(negedge clk); if_req = 1; if_addr = 32'h100; #1;
    chk("f_if_gnt", 32'(if_gnt), 1);
    chk("f_dm_gnt", 32'(dm_gnt), 0);
    chk("f_mem_en", 32'(mem_en), 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", 32'(mem_we), 0);
    chk("f_mem_be", 32'(mem_be), 0);
    @(negedge clk); if_req = 0; #1;
    chk("f_busy", 32'(busy), 1);
    chk("f_rvalid_c1", 32'(if_rvalid), 0);
    @(negedge clk); #1;
    chk("f_rvalid_c2", 32'(if_rvalid), 0);
    chk("f_dm_rvalid_c2", 32'(dm_rvalid), 0);
    @(negedge clk); #1;
    chk("f_rvalid_c3", 32'(if_rvalid), 1);
    chk("f_rdata_c3", if_rdata, 32'h0050_0093);
    chk("f_dm_rvalid_c3", 32'(dm_rvalid), 0);
    @(negedge clk); #1;
    chk("f_rvalid_c4", 32'(if_rvalid), 0);
    chk("f_busy_c4", 32'(busy), 0);
    chk("f_rdata_hold", if_rdata, 32'h0050_0093);

    // Data write
    @(negedge clk); dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF; #1;
    chk("w_dm_gnt", 32'(dm_gnt), 1);
    chk("w_mem_we", 32'(mem_we), 1);
    chk("w_mem_be", 32'(mem_be), 32'hF);
    chk("w_mem_addr", mem_addr, 32'h2000);
    chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk); dm_req = 0; dm_we = 0; #1;
    chk("w_rvalid_c1", 32'(dm_rvalid), 0);
    @(negedge clk); #1;
    chk("w_rvalid_c2", 32'(dm_rvalid), 0);
    @(negedge clk); #1;
    chk("w_rvalid_c3", 32'(dm_rvalid), 1);
    chk("w_rdata_zero", dm_rdata, 0);
    chk("w_if_rvalid_c3", 32'(if_rvalid), 0);

    // Read back, then back-to-back data request in the RESP cycle
    @(negedge clk); #1;
    chk("rb_idle", 32'(busy), 0);
    dm_req = 1; dm_addr = 32'h2000; dm_be = 4'h0; #1;
    chk("rb_dm_gnt", 32'(dm_gnt), 1);
    chk("rb_mem_we", 32'(mem_we), 0);
    @(negedge clk); dm_req = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); dm_req = 1; dm_addr = 32'h3000; #1;
    chk("b2b_rvalid", 32'(dm_rvalid), 1);
    chk("b2b_gnt", 32'(dm_gnt), 1);
    chk("b2b_old_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("b2b_mem_addr", mem_addr, 32'h3000);
    @(negedge clk); dm_req = 0; #1;
    chk("b2b_rvalid_off", 32'(dm_rvalid), 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("b2b_rvalid2", 32'(dm_rvalid), 1);
    chk("b2b_rdata2", dm_rdata, 32'hA5A5_3000);

    // Contention: both ports request continuously
    @(negedge clk); if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h44;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("cont_dm_gnt_%0d", k), 32'(dm_gnt), 32'(exp_dm[k]));
      chk($sformatf("cont_if_gnt_%0d", k), 32'(if_gnt), 32'(!exp_dm[k]));
      if (k > 0) begin
        chk($sformatf("cont_dm_rvalid_%0d", k), 32'(dm_rvalid), 32'(exp_dm[k-1]));
        chk($sformatf("cont_if_rvalid_%0d", k), 32'(if_rvalid), 32'(!exp_dm[k-1]));
      end
      @(negedge clk); #1;
      chk($sformatf("cont_wait_gnt_%0d", k), 32'(if_gnt | dm_gnt), 0);
      @(negedge clk);
      if (k == 9) begin
        if_req = 0; dm_req = 0;
      end
      @(negedge clk);
    end
    #1;
    chk("cont_last_if_rvalid", 32'(if_rvalid), 1);
    chk("cont_last_if_rdata", if_rdata, 32'hA5A5_0040);
    chk("cont_last_dm_rdata", dm_rdata, 32'hA5A5_0044);
    chk("cont_no_gnt", 32'(if_gnt | dm_gnt), 0);

    // Reset mid-access
    @(negedge clk); #1;
    @(negedge clk); if_req = 1; if_addr = 32'h100; #1;
    chk("rm_if_gnt", 32'(if_gnt), 1);
    @(negedge clk); if_req = 0; reset = 1'b0; #1;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_if_rvalid", 32'(if_rvalid), 0);
    chk("rm_mem_en", 32'(mem_en), 0);
    chk("rm_if_rdata", if_rdata, 0);
    chk("rm_dm_rdata", dm_rdata, 0);
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rm_no_rvalid_%0d", c), 32'(if_rvalid), 0);
      chk($sformatf("rm_idle_%0d", c), 32'(busy), 0);
      @(negedge clk);
    end
    if_req = 1; if_addr = 32'h104; #1;
    chk("rm_refetch_gnt", 32'(if_gnt), 1);
    @(negedge clk); if_req = 0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rm_refetch_rvalid", 32'(if_rvalid), 1);
    chk("rm_refetch_rdata", if_rdata, 32'hA5A5_0104);

    // MEM_LAT = 1 instance
    @(negedge clk); if_req1 = 1; if_addr1 = 32'h100; #1;
    chk("l1_if_gnt", 32'(if_gnt1), 1);
    chk("l1_mem_en", 32'(mem_en1), 1);
    @(negedge clk); if_req1 = 0; #1;
    chk("l1_rvalid_c1", 32'(if_rvalid1), 0);
    chk("l1_busy_c1", 32'(busy1), 1);
    @(negedge clk); #1;
    chk("l1_rvalid_c2", 32'(if_rvalid1), 1);
    chk("l1_rdata_c2", if_rdata1, 32'h0050_0093);
    @(negedge clk); #1;
    chk("l1_rvalid_c3", 32'(if_rvalid1), 0);
    chk("l1_busy_c3", 32'(busy1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
